// File: rtl/mod_inv_engine.sv
// Modular inverse engine: a^-1 mod m by the extended Euclidean algorithm with a
// shift-subtract divider. Define MOD_INV_NEG_EN to add the ninv = -a^-1 mod m output.
module mod_inv_engine #(
  parameter int W = 64
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [W-1:0] a,
  input  logic [W-1:0] m,
  output logic         busy,
  output logic         done,
  output logic         err,
  output logic [W-1:0] inv,
`ifdef MOD_INV_NEG_EN
  output logic [W-1:0] ninv,
`endif
  output logic [2:0]   dbg_state
);

  // Handshake: start is sampled only in IDLE (busy=0, done=0); busy is high from the
  // edge after an accepted start until the DONE cycle, where done pulses once and
  // inv/err are valid. inv/err then hold until the next accepted start.
  localparam int CW = $clog2(W);

`ifdef MOD_INV_NEG_EN
  typedef enum logic [2:0] {
    S_IDLE = 3'd0, S_INIT = 3'd1, S_DIV = 3'd2, S_UPDATE = 3'd3,
    S_FIX = 3'd4, S_NEG = 3'd5, S_DONE = 3'd6
  } state_t;
`else
  typedef enum logic [2:0] {
    S_IDLE = 3'd0, S_INIT = 3'd1, S_DIV = 3'd2, S_UPDATE = 3'd3,
    S_FIX = 3'd4, S_DONE = 3'd6
  } state_t;
`endif

  state_t state, state_nxt;

  logic [W-1:0]        m_q, r_prev, r, rem, div_sh;
  logic signed [W+1:0] t_prev, t, prod;
  logic [CW-1:0]       cnt;
  logic [W:0]          trial, trial_sub;
  logic                ge;
  logic                degenerate;
  logic signed [W+1:0] m_ext, t_fix;

  // One restoring-division step: bring in the next dividend bit and try to subtract.
  assign trial      = {rem, div_sh[W-1]};
  assign ge         = trial >= {1'b0, r};
  assign trial_sub  = trial - {1'b0, r};
  assign degenerate = (r_prev[W-1:1] == '0) || (r == '0);
  assign m_ext      = $signed({2'b00, m_q});
  assign t_fix      = t_prev[W+1] ? (t_prev + m_ext) : t_prev;

  always_ff @(posedge clk) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:   if (start) state_nxt = S_INIT;
      S_INIT:   state_nxt = degenerate ? S_DONE : S_DIV;
      S_DIV:    if (cnt == CW'(W-1)) state_nxt = S_UPDATE;
      S_UPDATE: state_nxt = (rem != '0) ? S_DIV : S_FIX;
`ifdef MOD_INV_NEG_EN
      S_FIX:    state_nxt = S_NEG;
      S_NEG:    state_nxt = S_DONE;
`else
      S_FIX:    state_nxt = S_DONE;
`endif
      S_DONE:   state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    busy      = !(state == S_IDLE || state == S_DONE);
    done      = (state == S_DONE);
    dbg_state = state;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      m_q    <= '0;
      r_prev <= '0;
      r      <= '0;
      rem    <= '0;
      div_sh <= '0;
      t_prev <= '0;
      t      <= '0;
      prod   <= '0;
      cnt    <= '0;
      err    <= 1'b0;
      inv    <= '0;
`ifdef MOD_INV_NEG_EN
      ninv   <= '0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            m_q    <= m;
            r_prev <= m;
            r      <= a;
          end
        end
        S_INIT: begin
          if (degenerate) begin
            err  <= 1'b1;
            inv  <= '0;
`ifdef MOD_INV_NEG_EN
            ninv <= '0;
`endif
          end else begin
            t_prev <= '0;
            t      <= (W+2)'(1);
            rem    <= '0;
            div_sh <= r_prev;
            prod   <= '0;
            cnt    <= '0;
          end
        end
        S_DIV: begin
          // prod accumulates q*t MSB-first alongside the quotient bits.
          rem    <= ge ? trial_sub[W-1:0] : trial[W-1:0];
          div_sh <= div_sh << 1;
          prod   <= (prod <<< 1) + (ge ? t : '0);
          cnt    <= cnt + CW'(1);
        end
        S_UPDATE: begin
          r_prev <= r;
          r      <= rem;
          t_prev <= t;
          t      <= t_prev - prod;
          div_sh <= r;
          rem    <= '0;
          prod   <= '0;
          cnt    <= '0;
        end
        S_FIX: begin
          if (r_prev != W'(1)) begin
            err <= 1'b1;
            inv <= '0;
          end else begin
            err <= 1'b0;
            inv <= t_fix[W-1:0];
          end
        end
`ifdef MOD_INV_NEG_EN
        S_NEG: begin
          ninv <= (err || inv == '0) ? '0 : (m_q - inv);
        end
`endif
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mod_inv_engine.sv
// Self-checking bench for mod_inv_engine: directed vectors, a reset abort, start
// during busy/DONE, and a set of random pairs checked against a wide-integer model.
module tb_mod_inv_engine;

  localparam int W = 64;
  localparam int BUDGET = (W + 1) * 2 * W + 8;
`ifdef MOD_INV_NEG_EN
  localparam int NEG_EXTRA = 1;
`else
  localparam int NEG_EXTRA = 0;
`endif

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic [W-1:0] a, m;
  logic         busy, done, err;
  logic [W-1:0] inv;
  logic [W-1:0] ninv;
  logic [2:0]   dbg_state;

  int n_cmp = 0;
  int n_bad = 0;

  logic [2*W:0] exp_q[$];
  logic [2*W:0] sb_e;

  mod_inv_engine #(.W(W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .a(a), .m(m),
    .busy(busy), .done(done), .err(err), .inv(inv),
`ifdef MOD_INV_NEG_EN
    .ninv(ninv),
`endif
    .dbg_state(dbg_state)
  );

`ifndef MOD_INV_NEG_EN
  assign ninv = '0;
`endif

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- checking helpers ----------------
  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // Reference: extended Euclid on wide signed integers using / directly.
  function automatic void ref_inv(input logic [W-1:0] av, input logic [W-1:0] mv,
                                  output logic [W-1:0] x, output logic e, output int steps);
    logic signed [2*W+1:0] r0, r1, t0, t1, q, tmp, mm;
    steps = 0;
    if (mv < 2 || av == 0) begin
      x = '0;
      e = 1'b1;
      return;
    end
    mm = {{(W+2){1'b0}}, mv};
    r0 = mm;
    r1 = {{(W+2){1'b0}}, av};
    t0 = 0;
    t1 = 1;
    while (r1 != 0) begin
      q   = r0 / r1;
      tmp = r0 - q * r1;  r0 = r1;  r1 = tmp;
      tmp = t0 - q * t1;  t0 = t1;  t1 = tmp;
      steps++;
    end
    if (r0 != 1) begin
      x = '0;
      e = 1'b1;
    end else begin
      if (t0 < 0) t0 = t0 + mm;
      x = t0[W-1:0];
      e = 1'b0;
    end
  endfunction

  function automatic logic [W-1:0] ref_neg(input logic [W-1:0] x, input logic e, input logic [W-1:0] mv);
    return (e || x == '0) ? '0 : (mv - x);
  endfunction

  // ---------------- scoreboard compare process ----------------
  always @(negedge clk) begin
    if (rst_n && done) begin
      check("busy_in_done", {{(W-1){1'b0}}, busy}, '0);
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL spurious_done: done=1 want 0 (no request outstanding)");
      end else begin
        sb_e = exp_q.pop_front();
        check("inv", inv, sb_e[W-1:0]);
        check("err", {{(W-1){1'b0}}, err}, {{(W-1){1'b0}}, sb_e[W]});
`ifdef MOD_INV_NEG_EN
        check("ninv", ninv, sb_e[2*W:W+1]);
`endif
      end
    end
  end

  // ---------------- driver ----------------
  // Returns at the negedge where done is seen (the DUT is then in its DONE cycle).
  task automatic run_op(input logic [W-1:0] av, input logic [W-1:0] mv, input int repulse);
    logic [W-1:0] x;
    logic         e;
    int           steps, lat, exp_lat;
    ref_inv(av, mv, x, e, steps);
    exp_q.push_back({ref_neg(x, e, mv), e, x});
    @(negedge clk);
    a = av;
    m = mv;
    start = 1'b1;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
      start = 1'b0;
      if (repulse != 0 && lat == repulse) begin
        start = 1'b1;
        a = ~av;
        m = mv + 2;
      end
    end while (!done && lat < BUDGET);
    start = 1'b0;
    if (!done) begin
      n_cmp++;
      n_bad++;
      $display("FAIL timeout: no done after %0d cycles (want done)", lat);
      void'(exp_q.pop_back());
    end else begin
      exp_lat = (mv < 2 || av == 0) ? 2 : 3 + steps * (W + 1) + NEG_EXTRA;
      check("latency", W'(lat), W'(exp_lat));
    end
  endtask

  // ---------------- main sequence ----------------
  logic [W-1:0] mx;
  logic         me;
  int           ms;
  logic [W-1:0] hold_inv;
  logic [2*W-1:0] prodmod;

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    a = '0;
    m = '0;

    // Pin the model with hand-computed values.
    ref_inv(64'd3, 64'd7, mx, me, ms);
    check("model_3_7", mx, 64'd5);
    check("model_3_7_steps", W'(ms), 64'd2);
    check("model_neg_3_7", ref_neg(mx, me, 64'd7), 64'd2);
    ref_inv(64'd17, 64'd3120, mx, me, ms);
    check("model_17_3120", mx, 64'd2753);
    check("model_neg_17_3120", ref_neg(mx, me, 64'd3120), 64'd367);
    ref_inv(64'd10, 64'd7, mx, me, ms);
    check("model_10_7", mx, 64'd5);
    ref_inv(64'd6, 64'd9, mx, me, ms);
    check("model_6_9_err", {{(W-1){1'b0}}, me}, 64'd1);

    repeat (3) @(negedge clk);
    check("rst_busy", {{(W-1){1'b0}}, busy}, '0);
    check("rst_done", {{(W-1){1'b0}}, done}, '0);
    check("rst_err",  {{(W-1){1'b0}}, err},  '0);
    check("rst_inv",  inv, '0);
    check("rst_ninv", ninv, '0);
    rst_n = 1'b1;

    // Directed vectors.
    run_op(64'd3, 64'd7, 0);
    run_op(64'd17, 64'd3120, 0);
    run_op(64'd10, 64'd7, 0);
    run_op(64'd6, 64'd9, 0);
    run_op(64'd6, 64'd1, 0);
    run_op(64'd0, 64'd7, 0);
    run_op(64'd5, 64'd0, 0);
    run_op(64'd7, 64'd7, 0);
    run_op(64'd1, 64'd2, 0);

    // Start re-pulsed while busy must be ignored.
    run_op(64'd3, 64'd7, 5);

    // Start during the DONE cycle must be ignored; outputs hold.
    hold_inv = inv;
    start = 1'b1;
    a = 64'd17;
    m = 64'd3120;
    @(negedge clk);
    start = 1'b0;
    check("start_in_done_busy", {{(W-1){1'b0}}, busy}, '0);
    repeat (4) @(negedge clk);
    check("start_in_done_busy_later", {{(W-1){1'b0}}, busy}, '0);
    check("inv_hold", inv, hold_inv);

    // Reset 40 cycles into a computation aborts it with no done pulse.
    @(negedge clk);
    a = 64'd17;
    m = 64'd3120;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (39) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("abort_busy", {{(W-1){1'b0}}, busy}, '0);
    check("abort_done", {{(W-1){1'b0}}, done}, '0);
    check("abort_inv", inv, '0);
    check("abort_err", {{(W-1){1'b0}}, err}, '0);
    repeat (2 * W) @(negedge clk);

    // Full-width modulus after the abort.
    run_op(64'd65537, 64'hFFFF_FFFF_FFFF_FFC5, 0);
    prodmod = ({64'd0, 64'd65537} * {64'd0, inv}) % {64'd0, 64'hFFFF_FFFF_FFFF_FFC5};
    check("w64_product", prodmod[W-1:0], 64'd1);

    // Random 32-bit pairs.
    for (int i = 0; i < 24; i++) begin
      run_op({32'd0, 32'($urandom())}, {32'd0, 32'($urandom())}, 0);
    end
    for (int i = 0; i < 6; i++) begin
      run_op({32'd0, 32'($urandom_range(1, 1000))}, {32'd0, 32'($urandom_range(0, 50))}, 0);
    end

    repeat (5) @(negedge clk);
    check("queue_drained", W'(exp_q.size()), '0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
